// File: rtl/instr_emitter_pkg.sv
// Shared nic8 instruction encoding: field widths, opcode bit positions and symbolic codes.
// Used by both the instruction emitter and the CPU control decoder.
package instr_emitter_pkg;

    localparam int COND_W   = 2;
    localparam int SRC_W    = 2;
    localparam int DST_W    = 3;
    localparam int OPCODE_W = 8;
    localparam int IMM_W    = 8;

    // Opcode layout: {cond[7:6], src[5:4], dst[3:1], indexed[0]}
    localparam int OP_IDX_BIT  = 0;
    localparam int OP_DST_LSB  = 1;
    localparam int OP_SRC_LSB  = 4;
    localparam int OP_COND_LSB = 6;

    typedef enum logic [SRC_W-1:0] {
        SRC_M = 2'd0,
        SRC_E = 2'd1,
        SRC_A = 2'd2,
        SRC_X = 2'd3
    } src_e;

    typedef enum logic [DST_W-1:0] {
        DST_IR   = 3'd0,
        DST_PC   = 3'd1,
        DST_A    = 3'd2,
        DST_X    = 3'd3,
        DST_B    = 3'd4,
        DST_MEM  = 3'd5,
        DST_OUT  = 3'd6,
        DST_NONE = 3'd7
    } dst_e;

    typedef enum logic [COND_W-1:0] {
        COND_NONE   = 2'd0,
        COND_Z      = 2'd1,
        COND_C      = 2'd2,
        COND_ALWAYS = 2'd3
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_IMM  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/instr_emitter_if.sv
// Request handshake and program-memory write port of the instruction emitter.
// slave = the emitter itself, master = the loader/bench driving requests and modelling memory.
interface instr_emitter_if
    import instr_emitter_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
);
    logic                req_valid;
    logic                req_ready;
    logic [COND_W-1:0]   req_cond;
    logic [SRC_W-1:0]    req_src;
    logic [DST_W-1:0]    req_dst;
    logic                req_indexed;
    logic [IMM_W-1:0]    req_imm;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [OPCODE_W-1:0] mem_wdata;
    logic                mem_ready;

    modport slave (
        input  req_valid, req_cond, req_src, req_dst, req_indexed, req_imm, mem_ready,
        output req_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_cond, req_src, req_dst, req_indexed, req_imm, mem_ready,
        input  req_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/instr_pack.sv
// Packs symbolic instruction fields into the nic8 opcode byte; every field value is legal.
module instr_pack
    import instr_emitter_pkg::*;
(
    input  logic [COND_W-1:0]   cond,
    input  logic [SRC_W-1:0]    src,
    input  logic [DST_W-1:0]    dst,
    input  logic                indexed,
    output logic [OPCODE_W-1:0] opcode
);

    always_comb begin
        opcode                              = '0;
        opcode[OP_COND_LSB +: COND_W]       = cond;
        opcode[OP_SRC_LSB  +: SRC_W]        = src;
        opcode[OP_DST_LSB  +: DST_W]        = dst;
        opcode[OP_IDX_BIT]                  = indexed;
    end

endmodule

// File: rtl/instr_emitter.sv
// Accepts symbolic instruction requests and writes opcode (+ operand for immediate forms)
// sequentially into program memory, tracking completed instructions and address overflow.
module instr_emitter
    import instr_emitter_pkg::*;
#(
    parameter int unsigned       ADDR_W = 8,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_base,
    input  logic [ADDR_W-1:0] base_addr,
    instr_emitter_if.slave    bus,
    output logic [7:0]        instr_count,
    output logic              overflow
);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [IMM_W-1:0]      imm_q, imm_d;
    logic                  indexed_q, indexed_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            count_q, count_d;
    logic                  mem_we_q, mem_we_d;
    logic [OPCODE_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic [OPCODE_W-1:0]   req_opcode;
    logic                  req_ready_c;
    logic                  at_top;

    instr_pack u_pack (
        .cond    (bus.req_cond),
        .src     (bus.req_src),
        .dst     (bus.req_dst),
        .indexed (bus.req_indexed),
        .opcode  (req_opcode)
    );

    // load_base takes priority over a request, so it also drops ready.
    assign req_ready_c = (state_q == ST_IDLE) && !overflow_q && !load_base;
    assign at_top      = &ptr_q;

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a latch behind.
        state_d     = state_q;
        ptr_d       = ptr_q;
        imm_d       = imm_q;
        indexed_d   = indexed_q;
        overflow_d  = overflow_q;
        count_d     = count_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (load_base) begin
                    ptr_d      = base_addr;
                    overflow_d = 1'b0;
                end else if (bus.req_valid && req_ready_c) begin
                    imm_d       = bus.req_imm;
                    indexed_d   = bus.req_indexed;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = req_opcode;
                    state_d     = ST_OP;
                end
            end
            ST_OP: begin
                if (bus.mem_ready) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (at_top) overflow_d = 1'b1;
                    // An opcode at the top address truncates an immediate form.
                    if (!indexed_q && !at_top) begin
                        mem_wdata_d = imm_q;
                        state_d     = ST_IMM;
                    end else begin
                        mem_we_d = 1'b0;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_IMM: begin
                if (bus.mem_ready) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (at_top) overflow_d = 1'b1;
                    mem_we_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                count_d = count_q + 8'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= BASE;
            imm_q       <= '0;
            indexed_q   <= 1'b0;
            overflow_q  <= 1'b0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            imm_q       <= imm_d;
            indexed_q   <= indexed_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = ptr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign instr_count   = count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_instr_emitter.sv
// Directed bench for instr_emitter: table of single instructions plus stall, overflow,
// truncation, reset-during-write and load_base precedence sequences.
module tb_instr_emitter;
    import instr_emitter_pkg::*;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_base;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        instr_count;
    logic              overflow;

    instr_emitter_if #(.ADDR_W(ADDR_W)) bus ();

    instr_emitter #(.ADDR_W(ADDR_W), .BASE(8'h00)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_base   (load_base),
        .base_addr   (base_addr),
        .bus         (bus.slave),
        .instr_count (instr_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cond;
        logic [1:0] src;
        logic [2:0] dst;
        logic       indexed;
        logic [7:0] imm;
        logic [7:0] exp_op;
    } vec_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wq[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_ptr;
    logic [7:0] exp_count;
    vec_t       vecs[7];
    vec_t       v_ldi;
    vec_t       v_out;

    // Memory model: record every accepted write.
    always @(posedge clk) begin
        if (!reset && bus.mem_we && bus.mem_ready)
            wq.push_back(wr_t'{bus.mem_addr, bus.mem_wdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_cond    = v.cond;
        bus.req_src     = v.src;
        bus.req_dst     = v.dst;
        bus.req_indexed = v.indexed;
        bus.req_imm     = v.imm;
        bus.req_valid   = 1'b1;
    endtask

    // Issue one request (mem_ready set by caller) and wait for instr_count to move.
    task automatic issue(input vec_t v, input int exp_edges, input string tag);
        int         g;
        int         edges;
        logic [7:0] c0;
        wq.delete();
        drive_req(v);
        #1;
        g = 0;
        while (!bus.req_ready && g < 20) begin
            step();
            g++;
        end
        check({tag, " accepted"}, bus.req_ready, 1);
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check({tag, " first we"}, bus.mem_we, 1);
        check({tag, " first wdata"}, bus.mem_wdata, v.exp_op);
        c0    = instr_count;
        edges = 0;
        while (instr_count == c0 && edges < 20) begin
            step();
            edges++;
        end
        check({tag, " latency"}, edges, exp_edges);
    endtask

    task automatic check_writes(input string tag, input int n,
                                input logic [7:0] a0, input logic [7:0] d0,
                                input logic [7:0] a1, input logic [7:0] d1);
        check({tag, " nwr"}, wq.size(), n);
        if (wq.size() >= 1) begin
            check({tag, " wr0 addr"}, wq[0].addr, a0);
            check({tag, " wr0 data"}, wq[0].data, d0);
        end
        if (n == 2 && wq.size() >= 2) begin
            check({tag, " wr1 addr"}, wq[1].addr, a1);
            check({tag, " wr1 data"}, wq[1].data, d1);
        end
    endtask

    task automatic do_load(input logic [7:0] val, input string tag);
        load_base     = 1'b1;
        base_addr     = val;
        bus.req_valid = 1'b0;
        #1;
        check({tag, " ready low"}, bus.req_ready, 0);
        step();
        load_base = 1'b0;
        check({tag, " ptr"}, bus.mem_addr, val);
        check({tag, " ovf clr"}, overflow, 0);
    endtask

    // Hold one write stalled for three cycles, then accept it.
    task automatic stall_write(input logic [7:0] a, input logic [7:0] d, input string tag);
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check({tag, " stall we"}, bus.mem_we, 1);
            check({tag, " stall addr"}, bus.mem_addr, a);
            check({tag, " stall data"}, bus.mem_wdata, d);
            check({tag, " stall ready"}, bus.req_ready, 0);
            step();
        end
        bus.mem_ready = 1'b1;
        check({tag, " accept addr"}, bus.mem_addr, a);
        check({tag, " accept data"}, bus.mem_wdata, d);
        step();
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = vec_t'{2'd0, 2'd2, 3'd6, 1'b1, 8'h00, 8'h2D};
        vecs[1] = vec_t'{2'd0, 2'd1, 3'd2, 1'b0, 8'h05, 8'h14};
        vecs[2] = vec_t'{2'd3, 2'd0, 3'd1, 1'b0, 8'h10, 8'hC2};
        vecs[3] = vec_t'{2'd2, 2'd3, 3'd7, 1'b1, 8'h55, 8'hBF};
        vecs[4] = vec_t'{2'd1, 2'd2, 3'd5, 1'b0, 8'hA5, 8'h6A};
        vecs[5] = vec_t'{2'd3, 2'd3, 3'd7, 1'b0, 8'hFF, 8'hFE};
        vecs[6] = vec_t'{2'd0, 2'd0, 3'd0, 1'b1, 8'h00, 8'h01};
        v_ldi   = vecs[1];
        v_out   = vecs[0];

        reset           = 1'b1;
        load_base       = 1'b0;
        base_addr       = '0;
        bus.req_valid   = 1'b0;
        bus.req_cond    = '0;
        bus.req_src     = '0;
        bus.req_dst     = '0;
        bus.req_indexed = 1'b0;
        bus.req_imm     = '0;
        bus.mem_ready   = 1'b0;
        step();
        step();
        check("rst mem_we", bus.mem_we, 0);
        check("rst mem_addr", bus.mem_addr, 8'h00);
        check("rst mem_wdata", bus.mem_wdata, 8'h00);
        check("rst count", instr_count, 0);
        check("rst overflow", overflow, 0);
        reset = 1'b0;
        #1;
        check("rst req_ready", bus.req_ready, 1);

        // Table: back-to-back instructions with memory always ready.
        exp_ptr       = 8'h00;
        exp_count     = 8'h00;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            string tag;
            int    nb;
            tag = $sformatf("vec%0d", i);
            nb  = vecs[i].indexed ? 1 : 2;
            issue(vecs[i], nb + 1, tag);
            exp_count++;
            check({tag, " count"}, instr_count, exp_count);
            check_writes(tag, nb, exp_ptr, vecs[i].exp_op, exp_ptr + 8'd1, vecs[i].imm);
            exp_ptr = exp_ptr + 8'(nb);
            check({tag, " ptr"}, bus.mem_addr, exp_ptr);
            check({tag, " ovf"}, overflow, 0);
        end

        // Unconditional jump with both writes stalled.
        wq.delete();
        bus.mem_ready = 1'b0;
        drive_req(vecs[2]);
        #1;
        check("jmp ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        stall_write(exp_ptr, 8'hC2, "jmp op");
        stall_write(exp_ptr + 8'd1, 8'h10, "jmp imm");
        check("jmp done we", bus.mem_we, 0);
        check("jmp done ready", bus.req_ready, 0);
        step();
        exp_count++;
        check("jmp count", instr_count, exp_count);
        check_writes("jmp", 2, exp_ptr, 8'hC2, exp_ptr + 8'd1, 8'h10);
        check("jmp idle ready", bus.req_ready, 1);

        // Overflow on the operand write at 0xFF.
        bus.mem_ready = 1'b1;
        do_load(8'hFE, "ld FE");
        issue(v_ldi, 3, "ovf");
        exp_count++;
        check("ovf count", instr_count, exp_count);
        check_writes("ovf", 2, 8'hFE, 8'h14, 8'hFF, 8'h05);
        check("ovf flag", overflow, 1);
        check("ovf ptr wrap", bus.mem_addr, 8'h00);
        bus.req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("ovf blocks ready", bus.req_ready, 0);
            step();
        end
        bus.req_valid = 1'b0;
        check("ovf no write", wq.size(), 2);
        check("ovf we idle", bus.mem_we, 0);

        do_load(8'h20, "ld 20");
        issue(v_out, 2, "post ovf");
        exp_count++;
        check("post ovf count", instr_count, exp_count);
        check_writes("post ovf", 1, 8'h20, 8'h2D, 8'h00, 8'h00);
        check("post ovf ptr", bus.mem_addr, 8'h21);

        // Truncation: immediate opcode at the top address.
        do_load(8'hFF, "ld FF");
        issue(v_ldi, 2, "trunc");
        exp_count++;
        check("trunc count", instr_count, exp_count);
        check_writes("trunc", 1, 8'hFF, 8'h14, 8'h00, 8'h00);
        check("trunc ovf", overflow, 1);
        check("trunc ptr", bus.mem_addr, 8'h00);

        // Reset while the operand write is stalled.
        do_load(8'h40, "ld 40");
        wq.delete();
        drive_req(v_ldi);
        #1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        step();
        bus.mem_ready = 1'b0;
        check("rimm we", bus.mem_we, 1);
        check("rimm addr", bus.mem_addr, 8'h41);
        check("rimm data", bus.mem_wdata, 8'h05);
        step();
        reset = 1'b1;
        step();
        check("rimm rst we", bus.mem_we, 0);
        check("rimm rst ptr", bus.mem_addr, 8'h00);
        check("rimm rst count", instr_count, 0);
        check("rimm rst ovf", overflow, 0);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        check_writes("rimm", 1, 8'h40, 8'h14, 8'h00, 8'h00);

        // load_base and req_valid together: load wins, request not taken.
        wq.delete();
        load_base = 1'b1;
        base_addr = 8'h80;
        drive_req(v_out);
        #1;
        check("prec ready", bus.req_ready, 0);
        step();
        load_base     = 1'b0;
        bus.req_valid = 1'b0;
        check("prec ptr", bus.mem_addr, 8'h80);
        check("prec we", bus.mem_we, 0);
        step();
        check("prec we later", bus.mem_we, 0);
        check("prec count", instr_count, 0);
        check("prec no write", wq.size(), 0);
        check("prec idle ready", bus.req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
